// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, FSM states and op-class helpers.
// Also imported by the hazard unit for is_multicycle().
package mdu_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MADD  = 4'd7,
        MADDU = 4'd8,
        MSUB  = 4'd9,
        MSUBU = 4'd10
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } mdu_state_e;

    function automatic logic is_div(input mdu_op_e op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_mul(input mdu_op_e op);
        return (op == MULT) || (op == MULTU) ||
               (op == MADD) || (op == MADDU) ||
               (op == MSUB) || (op == MSUBU);
    endfunction

    function automatic logic is_multicycle(input mdu_op_e op);
        return is_mul(op) || is_div(op);
    endfunction

    function automatic logic is_signed_op(input mdu_op_e op);
        return (op == MULT) || (op == MADD) ||
               (op == MSUB) || (op == DIV);
    endfunction

    function automatic logic is_accum(input mdu_op_e op);
        return (op == MADD) || (op == MADDU) ||
               (op == MSUB) || (op == MSUBU);
    endfunction

    function automatic logic is_sub(input mdu_op_e op);
        return (op == MSUB) || (op == MSUBU);
    endfunction

endpackage

// File: rtl/mdu_iter_div_serial.sv
// Bit-serial restoring divider on operand magnitudes with sign fix-up.
// quotient/remainder reflect the state after the step taken this cycle.
module div_serial
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_op,
    input  logic             step,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             qneg_q;
    logic             rneg_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;

    assign a_neg = signed_op & dividend[WIDTH-1];
    assign b_neg = signed_op & divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign fits    = ~diff[WIDTH];
    assign rem_n   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_n   = {quo_q[WIDTH-2:0], fits};

    assign quotient  = qneg_q ? -quo_n : quo_n;
    assign remainder = rneg_q ? -rem_n : rem_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (load) begin
            rem_q  <= '0;
            quo_q  <= a_mag;
            dvs_q  <= b_mag;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
        end else if (step) begin
            rem_q  <= rem_n;
            quo_q  <= quo_n;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO, accumulate ops and flush cancel.
// Multiply is a latched product plus latency counter; divide is bit-serial.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_MAX = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
    localparam int CW      = $clog2(CNT_MAX);

    mdu_op_e    op_e;
    mdu_state_e state_q;
    mdu_state_e state_d;

    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               acc_q;
    logic               sub_q;
    logic [WIDTH-1:0]   a_q;
    logic               dz_q;

    logic accept;
    logic mul_load;
    logic div_load;
    logic div_step;
    logic mul_commit;
    logic div_commit;

    logic               sgn;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] mul_result;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    assign op_e   = mdu_op_e'(op);
    assign accept = start & ~cancel & (state_q == S_IDLE);

    // Sign-extended operands give the signed product modulo 2^(2W).
    assign sgn     = is_signed_op(op_e);
    assign ext_a   = {{WIDTH{sgn & src_a[WIDTH-1]}}, src_a};
    assign ext_b   = {{WIDTH{sgn & src_b[WIDTH-1]}}, src_b};
    assign product = ext_a * ext_b;

    always_comb begin
        mul_result = prod_q;
        if (acc_q) begin
            mul_result = sub_q ? ({hi, lo} - prod_q) : ({hi, lo} + prod_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && is_mul(op_e)) begin
                    state_d = S_MUL;
                end else if (accept && is_div(op_e)) begin
                    state_d = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (cancel || cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mul_load   = 1'b0;
        div_load   = 1'b0;
        div_step   = 1'b0;
        mul_commit = 1'b0;
        div_commit = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                mul_load = accept & is_mul(op_e);
                div_load = accept & is_div(op_e);
            end
            S_MUL: begin
                mul_commit = ~cancel & (cnt_q == '0);
            end
            S_DIV: begin
                div_step   = 1'b1;
                div_commit = ~cancel & (cnt_q == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy   <= 1'b0;
            cnt_q  <= '0;
            prod_q <= '0;
            acc_q  <= 1'b0;
            sub_q  <= 1'b0;
            a_q    <= '0;
            dz_q   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            busy <= (state_d != S_IDLE);
            if (mul_load) begin
                prod_q <= product;
                acc_q  <= is_accum(op_e);
                sub_q  <= is_sub(op_e);
                cnt_q  <= CW'(MUL_CYCLES - 1);
            end else if (div_load) begin
                a_q   <= src_a;
                dz_q  <= (src_b == '0);
                cnt_q <= CW'(WIDTH - 1);
            end else if (state_q != S_IDLE && cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (accept && op_e == MTHI) begin
                hi <= src_a;
            end
            if (accept && op_e == MTLO) begin
                lo <= src_a;
            end
            if (mul_commit) begin
                {hi, lo} <= mul_result;
            end
            // Divide by zero bypasses the serial result entirely.
            if (div_commit) begin
                hi <= dz_q ? a_q : remainder;
                lo <= dz_q ? '1 : quotient;
            end
        end
    end

    div_serial #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .dividend  (src_a),
        .divisor   (src_b),
        .signed_op (op_e == DIV),
        .step      (div_step),
        .quotient  (quotient),
        .remainder (remainder)
    );

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter with an arithmetic reference model
// compared against busy/hi/lo every cycle.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int W   = 32;
    localparam int MUL = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    op;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          cancel;
    logic          busy;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_iter #(
        .WIDTH(W),
        .MUL_CYCLES(MUL)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [3:0] o,
                                               input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [63:0] hl);
        longint       sa;
        longint       sb;
        longint       q;
        longint       m;
        logic [63:0]  ua;
        logic [63:0]  ub;
        logic [63:0]  r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = hl;
        case (o)
            MULT:  r = sa * sb;
            MULTU: r = ua * ub;
            MADD:  r = hl + sa * sb;
            MADDU: r = hl + ua * ub;
            MSUB:  r = hl - sa * sb;
            MSUBU: r = hl - ua * ub;
            DIV, DIVU: begin
                if (b == 0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else if (o == DIV) begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end else begin
                    q = longint'(ua / ub);
                    m = longint'(ua % ub);
                    r = {m[31:0], q[31:0]};
                end
            end
            default: r = hl;
        endcase
        return r;
    endfunction

    // Reference model: m_rem is the number of busy cycles still owed.
    int          m_rem = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rem  <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_pend <= '0;
        end else if (m_rem != 0) begin
            if (cancel) begin
                m_rem <= 0;
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hi <= m_pend[63:32];
                    m_lo <= m_pend[31:0];
                end
            end
        end else if (start && !cancel) begin
            if (op == MTHI) m_hi <= src_a;
            if (op == MTLO) m_lo <= src_a;
            if (is_multicycle(mdu_op_e'(op))) begin
                m_pend <= ref_result(op, src_a, src_b, {m_hi, m_lo});
                m_rem  <= is_div(mdu_op_e'(op)) ? W : MUL;
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_busy", {63'd0, busy}, {63'd0, m_rem != 0});
        check("cyc_hilo", {hi, lo}, {m_hi, m_lo});
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: busy still %b after %0d cycles", busy, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, busy=%b", busy);
        $fatal(1);
    end

    initial begin
        int n;
        reset  = 1'b1;
        start  = 1'b0;
        op     = NOP;
        src_a  = '0;
        src_b  = '0;
        cancel = 1'b0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #2;

        issue(MULT, 32'hFFFF_FFFF, 32'h2);
        wait_idle(n);
        check("mult_cycles", 64'(n), 64'd5);
        check("mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(MULTU, 32'hFFFF_FFFF, 32'h2);
        wait_idle(n);
        check("multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        issue(DIVU, 32'd100, 32'd7);
        wait_idle(n);
        check("divu_cycles", 64'(n), 64'd32);
        check("divu", {hi, lo}, {32'd2, 32'd14});
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(DIV, 32'd7, 32'hFFFF_FFFE);
        wait_idle(n);
        check("div_negb", {hi, lo}, {32'd1, 32'hFFFF_FFFD});
        issue(DIV, 32'd5, 32'd0);
        wait_idle(n);
        check("div_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        issue(DIV, 32'hFFFF_FFF7, 32'd0);
        wait_idle(n);
        check("div_zero_neg", {hi, lo}, {32'hFFFF_FFF7, 32'hFFFF_FFFF});
        issue(DIVU, 32'h8000_0005, 32'd0);
        wait_idle(n);
        check("divu_zero", {hi, lo}, {32'h8000_0005, 32'hFFFF_FFFF});
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});

        issue(MTHI, 32'd0, 32'd0);
        issue(MTLO, 32'd10, 32'd0);
        check("mtlo_busy", {63'd0, busy}, 64'd0);
        issue(MADD, 32'd3, 32'd4);
        wait_idle(n);
        check("madd", {hi, lo}, {32'd0, 32'd22});
        issue(MSUBU, 32'd5, 32'd5);
        wait_idle(n);
        check("msubu", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(MTHI, 32'h11, 32'd0);
        issue(MTLO, 32'h22, 32'd0);
        issue(MULT, 32'd6, 32'd7);
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        cancel = 1'b1;
        @(posedge clk);
        #2;
        cancel = 1'b0;
        check("cancel_busy", {63'd0, busy}, 64'd0);
        check("cancel_hilo", {hi, lo}, {32'h11, 32'h22});

        cancel = 1'b1;
        issue(MTHI, 32'h99, 32'd0);
        check("startcan_hi", {hi, lo}, {32'h11, 32'h22});
        issue(DIVU, 32'd9, 32'd3);
        cancel = 1'b0;
        check("startcan_busy", {63'd0, busy}, 64'd0);

        issue(MULTU, 32'd3, 32'd3);
        issue(MTLO, 32'h77, 32'd0);
        wait_idle(n);
        check("busy_ignore_n", 64'(n), 64'd4);
        check("busy_ignore", {hi, lo}, {32'd0, 32'd9});

        issue(DIVU, 32'd100, 32'd7);
        repeat (5) begin
            @(posedge clk);
            #2;
        end
        reset = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        issue(MTHI, 32'hABCD, 32'd0);
        check("mthi_hi", {32'd0, hi}, 64'hABCD);
        check("mthi_busy", {63'd0, busy}, 64'd0);

        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised multiply/divide unit for the EX stage, the successor to the fixed 32-bit MDU. It adds configurable data width and multiply latency, a bit-serial divider, MADD/MADDU/MSUB/MSUBU accumulate ops, defined divide-by-zero results, and a `cancel` input so that the exception/interrupt flush can abort an in-flight operation. It sits beside the ALU. Its operands come from the forwarded rs/rt values. `busy` feeds the hazard unit, and `hi`/`lo` feed the MDU result mux.

## Interface
- `WIDTH`, default 32: operand and HI/LO width, must be ≥ 4.
- `MUL_CYCLES`, default 5: busy cycles for multiply-class ops, must be ≥ 1.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: an op is valid in EX this cycle.
- `op` in 4: operation code (package `mdu_op_e`).
- `src_a` in WIDTH: rs operand, already forwarded.
- `src_b` in WIDTH: rt operand, already forwarded.
- `cancel` in 1: flush. Aborts the in-flight op and blocks `start` in the same cycle.
- `busy` out 1: unit is occupied (registered).
- `hi` out WIDTH: architectural HI register.
- `lo` out WIDTH: architectural LO register.

## Operation
- States: IDLE, MUL, DIV.
- Reset (`reset`=0) forces IDLE with `busy`=0, `hi`=0, `lo`=0, and the counter and scratch registers cleared. Reset takes effect immediately, including mid-operation.
- Accept condition: `start`=1 && `cancel`=0 && state==IDLE. A `start` that arrives while the unit is busy is ignored with no side effect.
- MTHI/MTLO: `hi`/`lo` ← `src_a` at the accepting edge. The unit stays in IDLE and `busy` stays 0.
- MULT/MULTU: the 2·WIDTH signed or unsigned product is latched at acceptance. Transition IDLE→MUL with the counter set to MUL_CYCLES−1.
- MADD/MADDU/MSUB/MSUBU: same timing as MULT/MULTU. The committed value is {hi,lo} ± product, taken modulo 2^(2·WIDTH). The {hi,lo} used is the value current at commit.
- DIV/DIVU: restoring divider, one quotient bit per cycle. Transition IDLE→DIV for WIDTH cycles.
  - Signed ops divide magnitudes, then fix up signs.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Quotient goes to `lo`, remainder to `hi`.
- Divide by zero: `lo` = all-ones, `hi` = `src_a`, for both signed and unsigned.
- Signed overflow (most-negative / −1): `lo` = most-negative, `hi` = 0.
- Commit: on the edge where the counter is 0, `hi`/`lo` are written and the state returns to IDLE.
- Cancel in MUL or DIV: the unit returns to IDLE on the next edge and `hi`/`lo` are unchanged.
- If `cancel` and the final commit edge coincide, cancel wins and there is no write.

## Timing
- An op is accepted at edge E0.
- Multiply class: `busy`=1 for exactly MUL_CYCLES cycles after E0. New `hi`/`lo` are visible in the first cycle with `busy`=0.
- Divide: `busy`=1 for exactly WIDTH cycles. It is 32 cycles at the defaults.
- `busy` is registered, so it is still 0 in the cycle `start` is asserted. The hazard unit must treat (`start` && op-is-multicycle) as busy.
- The hazard unit stalls MFHI/MFLO and other MDU ops while `busy` is 1. The unit itself never queues an op.
- Back-to-back ops: a new op can be accepted in the first cycle that `busy` is 0.
- `cancel` is combinationally sampled each cycle. It has no effect in IDLE other than blocking `start`.

## Structure
- Package `mdu_pkg` holds:
  - `mdu_op_e`: NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU.
  - The state enum.
  - Helper `is_multicycle(op)`, shared with the hazard unit.
- Sub-module `div_serial`, parametrised by WIDTH:
  - Interface: load, dividend, divisor, sign flags, step enable.
  - Returns quotient and remainder after WIDTH steps.
- The multiplier stays inline, as a behavioural product plus a latency counter.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 → after 5 busy cycles `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE. MULTU on the same operands → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- DIVU 100/7 → `busy` high for 32 cycles, then `lo`=14, `hi`=2. DIV 0xFFFFFFF9/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV 5/0 → `lo`=0xFFFFFFFF, `hi`=5. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTHI 0, MTLO 10, then MADD 3×4 → `lo`=22, `hi`=0. Then MSUBU 5×5 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- Preload `hi`/`lo`=0x11/0x22, then:
  - MULT, with `cancel` asserted in its 3rd busy cycle → `busy`=0 next cycle, `hi`/`lo` stay 0x11/0x22.
  - `start`+`cancel` in the same cycle → no state change.
  - `start` while busy → ignored.
- `reset` pulled low mid-DIV → `busy`, `hi`, `lo` = 0 immediately. After release, MTHI 0xABCD → `hi`=0xABCD at the next edge with `busy` still 0.
